ula_logic_sequencer: RTL and testbench

//  Sequences the 8-bit-in / 16-bit-out ULA logic unit (AND, OR, NAND, XOR, NOR, NOT).

---
 rtl/ula_logic_sequencer.sv | 140 ++++++++++++++
 tb/tb_ula_logic_sequencer.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/ula_logic_sequencer.sv
// ULA logic-unit sequencer: cmd handshake -> one-cycle compute -> held response.
// Optional macro ULA_LOGIC_CHAIN_EN keeps last_res[7:0] so a command can reuse the previous result as A.
module ula_logic_sequencer #(
  parameter int COUNT_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [2:0]         cmd_op,
  input  logic [7:0]         cmd_a,
  input  logic [7:0]         cmd_b,
  input  logic               cmd_chain,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [15:0]        rsp_data,
  output logic               rsp_zero,
  output logic               rsp_err,
  output logic               busy,
  output logic [COUNT_W-1:0] op_count
);

  // state | meaning
  // IDLE  | ready for a command
  // EXEC  | computing, result registered at end of cycle
  // RESP  | response held until rsp_ready
  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

  state_t             state_q, state_d;
  logic [2:0]         op_q, op_d;
  logic [7:0]         a_q, a_d, b_q, b_d;
  logic [15:0]        data_q, data_d;
  logic               zero_q, zero_d, err_q, err_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic [15:0]        res;
  logic               legal;
  logic [7:0]         a_src;

`ifdef ULA_LOGIC_CHAIN_EN
  logic [7:0] last_res_q, last_res_d;

  assign a_src = cmd_chain ? last_res_q : cmd_a;

  always_comb begin
    last_res_d = last_res_q;
    if (state_q == RESP && rsp_ready && !err_q) last_res_d = data_q[7:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_res_q <= 8'h00;
    else        last_res_q <= last_res_d;
  end
`else
  logic unused_chain;
  assign unused_chain = cmd_chain;
  assign a_src = cmd_a;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cmd_valid) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (state_q == IDLE);
    rsp_valid = (state_q == RESP);
    busy      = (state_q != IDLE);
  end

  always_comb begin
    legal = 1'b1;
    res   = 16'h0000;
    case (op_q)
      3'd0:    res = {8'h00, a_q & b_q};
      3'd1:    res = {8'h00, a_q | b_q};
      3'd2:    res = {8'h00, ~(a_q & b_q)};
      3'd3:    res = {8'h00, a_q ^ b_q};
      3'd4:    res = {8'h00, ~(a_q | b_q)};
      3'd5:    res = ~{8'h00, a_q};
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    data_d  = data_q;
    zero_d  = zero_q;
    err_d   = err_q;
    count_d = count_q;
    if (state_q == IDLE && cmd_valid) begin
      op_d = cmd_op;
      a_d  = a_src;
      b_d  = cmd_b;
    end
    if (state_q == EXEC) begin
      data_d = res;
      zero_d = legal && (res == 16'h0000);
      err_d  = !legal;
    end
    if (state_q == RESP && rsp_ready) count_d = count_q + COUNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q    <= 3'd0;
      a_q     <= 8'h00;
      b_q     <= 8'h00;
      data_q  <= 16'h0000;
      zero_q  <= 1'b0;
      err_q   <= 1'b0;
      count_q <= '0;
    end else begin
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      data_q  <= data_d;
      zero_q  <= zero_d;
      err_q   <= err_d;
      count_q <= count_d;
    end
  end

  assign rsp_data = data_q;
  assign rsp_zero = zero_q;
  assign rsp_err  = err_q;
  assign op_count = count_q;

endmodule

// File: tb/tb_ula_logic_sequencer.sv
// Directed bench for ula_logic_sequencer, built with COUNT_W=2 so op_count wrap is reachable.
module tb_ula_logic_sequencer;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [2:0]    cmd_op = 3'd0;
  logic [7:0]    cmd_a = 8'h00;
  logic [7:0]    cmd_b = 8'h00;
  logic          cmd_chain = 1'b0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [15:0]   rsp_data;
  logic          rsp_zero;
  logic          rsp_err;
  logic          busy;
  logic [CW-1:0] op_count;

  int n_run  = 0;
  int n_fail = 0;
  int exp_count = 0;

  ula_logic_sequencer #(.COUNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_chain(cmd_chain),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_zero(rsp_zero), .rsp_err(rsp_err), .busy(busy), .op_count(op_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Presents a command and returns #1 after the accepting edge.
  task automatic send(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                      input logic chain);
    bit done = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b; cmd_chain = chain;
    for (int i = 0; i < 20 && !done; i++) begin
      if (cmd_ready) done = 1;
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0; cmd_chain = 1'b0;
    chk("accept_timeout", {31'd0, done}, 32'd1);
  endtask

  task automatic do_op(input string tag, input logic [2:0] op, input logic [7:0] a,
                       input logic [7:0] b, input logic chain,
                       input logic [15:0] ed, input logic ez, input logic ee);
    send(op, a, b, chain);
    chk({tag, "_exec_valid"}, {31'd0, rsp_valid}, 32'd0);
    chk({tag, "_exec_busy"}, {31'd0, busy}, 32'd1);
    @(posedge clk); #1;
    chk({tag, "_valid"}, {31'd0, rsp_valid}, 32'd1);
    chk({tag, "_data"}, {16'd0, rsp_data}, {16'd0, ed});
    chk({tag, "_zero"}, {31'd0, rsp_zero}, {31'd0, ez});
    chk({tag, "_err"}, {31'd0, rsp_err}, {31'd0, ee});
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    exp_count = (exp_count + 1) % (1 << CW);
    chk({tag, "_count"}, {30'd0, op_count}, exp_count);
    chk({tag, "_idle"}, {31'd0, cmd_ready}, 32'd1);
  endtask

  initial begin
    #12 rst_n = 1'b1;
    #1;
    chk("rst_ready", {31'd0, cmd_ready}, 32'd1);
    chk("rst_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_count", {30'd0, op_count}, 32'd0);
    chk("rst_data", {16'd0, rsp_data}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);

    do_op("and", 3'd0, 8'hF0, 8'h3C, 1'b0, 16'h0030, 1'b0, 1'b0);
    do_op("nor", 3'd4, 8'hFF, 8'h00, 1'b0, 16'h0000, 1'b1, 1'b0);
    do_op("not", 3'd5, 8'h0F, 8'h55, 1'b0, 16'hFFF0, 1'b0, 1'b0);
    do_op("nand", 3'd2, 8'hFF, 8'hFF, 1'b0, 16'h0000, 1'b1, 1'b0);
    chk("wrap", {30'd0, op_count}, 32'd0);

    // Stalled response with a second command waiting behind it
    send(3'd3, 8'hAA, 8'hAA, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 3'd1; cmd_a = 8'h01; cmd_b = 8'h02;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("stall_valid", {31'd0, rsp_valid}, 32'd1);
      chk("stall_data", {16'd0, rsp_data}, 32'd0);
      chk("stall_zero", {31'd0, rsp_zero}, 32'd1);
      chk("stall_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    exp_count = (exp_count + 1) % (1 << CW);
    chk("stall_count", {30'd0, op_count}, exp_count);
    chk("second_ready", {31'd0, cmd_ready}, 32'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    chk("second_exec", {31'd0, busy}, 32'd1);
    @(posedge clk); #1;
    chk("second_data", {16'd0, rsp_data}, 32'h0003);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    exp_count = (exp_count + 1) % (1 << CW);
    chk("second_count", {30'd0, op_count}, exp_count);

    do_op("ill6", 3'd6, 8'h12, 8'h34, 1'b0, 16'h0000, 1'b0, 1'b1);
    do_op("ill7", 3'd7, 8'hFF, 8'hFF, 1'b0, 16'h0000, 1'b0, 1'b1);

    do_op("or", 3'd1, 8'h0F, 8'h30, 1'b0, 16'h003F, 1'b0, 1'b0);
    do_op("ill_keep", 3'd6, 8'h00, 8'h00, 1'b0, 16'h0000, 1'b0, 1'b1);
`ifdef ULA_LOGIC_CHAIN_EN
    do_op("chain", 3'd3, 8'h00, 8'hFF, 1'b1, 16'h00C0, 1'b0, 1'b0);
`else
    do_op("chain", 3'd3, 8'h00, 8'hFF, 1'b1, 16'h00FF, 1'b0, 1'b0);
`endif

    // Reset during EXEC drops the command
    send(3'd0, 8'hFF, 8'hFF, 1'b0);
    chk("pre_rst_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_exec_busy", {31'd0, busy}, 32'd0);
    chk("rst_exec_count", {30'd0, op_count}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_count = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("rst_no_rsp", {31'd0, rsp_valid}, 32'd0);
    end
    chk("rst_exec_data", {16'd0, rsp_data}, 32'd0);
    chk("rst_exec_count2", {30'd0, op_count}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end
endmodule
